// File: rtl/ms_wb_arbiter2.sv
// ms_wb_arbiter2: two-master, one-slave Wishbone arbiter with round-robin
// arbitration. The grant is held for the whole bus cycle of the granted master.
// Optional slave-ack watchdog enabled by defining MS_WB_ARB_TIMEOUT_EN.
module ms_wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state;
    state_t state_nxt;
    logic   prefer_m1;
    logic   prefer_m1_nxt;
    logic   req0;
    logic   req1;
    logic   stb_raw;
    logic   to_hit;

    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;
    assign gnt_o = {state == GNT1, state == GNT0};

    // TIMEOUT only sizes the optional watchdog; an illegal value shows up as this named block
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_out_of_range
    end

    // State and round-robin pointer registers; reset favours m0
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            prefer_m1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            prefer_m1 <= prefer_m1_nxt;
        end
    end

    // Next-state: grant held while the owner keeps cyc, hand-over without an idle bubble
    always_comb begin
        state_nxt     = state;
        prefer_m1_nxt = prefer_m1;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || !prefer_m1)) state_nxt = GNT0;
                else if (req1)                     state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) state_nxt = req1 ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i) state_nxt = req0 ? GNT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == GNT0 && state != GNT0) prefer_m1_nxt = 1'b1;
        if (state_nxt == GNT1 && state != GNT1) prefer_m1_nxt = 1'b0;
    end

    // Datapath mux: forward the granted master to the slave and route ack/data back to it only
    always_comb begin
        s_cyc_o  = 1'b0;
        stb_raw  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                stb_raw  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | to_hit;
                m0_dat_o = to_hit ? DW'(32'hDEADBEEF) : s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                stb_raw  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | to_hit;
                m1_dat_o = to_hit ? DW'(32'hDEADBEEF) : s_dat_i;
            end
            default: ;
        endcase
        s_stb_o = stb_raw & ~to_hit;
    end

`ifdef MS_WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;

    // A genuine ack on the deadline cycle wins over the forced error ack
    assign to_hit    = stb_raw & ~s_ack_i & (to_cnt == CW'(TIMEOUT));
    assign timeout_o = to_hit;

    // Watchdog counts stalled strobe cycles and restarts on ack, idle strobe or expiry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt <= '0;
        end else if (!stb_raw || s_ack_i || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CW'(1);
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ms_wb_arbiter2.sv
// tb_ms_wb_arbiter2: directed self-checking bench for ms_wb_arbiter2.
// Timeout expectations follow MS_WB_ARB_TIMEOUT_EN; the DUT is built with TIMEOUT=8.
module tb_ms_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [DW/8-1:0] m0_sel_i = '0;
    logic [AW-1:0]   m0_adr_i = '0;
    logic [DW-1:0]   m0_dat_i = '0;
    logic [DW-1:0]   m0_dat_o;
    logic            m0_ack_o;
    logic            m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [DW/8-1:0] m1_sel_i = '0;
    logic [AW-1:0]   m1_adr_i = '0;
    logic [DW-1:0]   m1_dat_i = '0;
    logic [DW-1:0]   m1_dat_o;
    logic            m1_ack_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [DW/8-1:0] s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0;
    logic [1:0]      gnt_o;
    logic            timeout_o;

    int errors = 0;
    int checks = 0;

    ms_wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    // 100 MHz bus clock
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time limit expected earlier finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic c0, input logic s0, input logic c1,
                                 input logic s1, input logic ack);
        @(posedge clk);
        #1;
        m0_cyc_i = c0;
        m0_stb_i = s0;
        m1_cyc_i = c1;
        m1_stb_i = s1;
        s_ack_i  = ack;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n_i  = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n_i = 1'b1;
    endtask

    initial begin
        int cnt0, cnt1, nack, nto, ack_k, to_k;
        logic drop0, drop1;
        logic [1:0] exp_g;
        logic [31:0] wr_q[$];
        logic [31:0] exp_wr[3];

        // Reset state, with requests and a slave ack present during reset
        rst_n_i  = 1'b0;
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
        #12;
        checkOutput("rst_gnt", gnt_o, 2'b00);
        checkOutput("rst_s_cyc", s_cyc_o, 1'b0);
        checkOutput("rst_s_stb", s_stb_o, 1'b0);
        checkOutput("rst_s_adr", s_adr_o, 32'h0);
        checkOutput("rst_m0_ack", m0_ack_o, 1'b0);
        checkOutput("rst_m0_dat", m0_dat_o, 32'h0);
        checkOutput("rst_timeout", timeout_o, 1'b0);
        resetDut();

        // Idle: stb without cyc ignored, stray slave ack not forwarded
        s_dat_i = 32'h0000_0055;
        applyStimulus(0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("idle_ack_m0", m0_ack_o, 1'b0);
        checkOutput("idle_ack_m1", m1_ack_o, 1'b0);
        checkOutput("idle_dat_m1", m1_dat_o, 32'h0);
        applyStimulus(0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("stb_no_cyc_gnt", gnt_o, 2'b00);

        // Single read by m0
        m0_adr_i = 32'h3000_0004; m0_we_i = 0; m0_sel_i = 4'hF;
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd_latency_gnt", gnt_o, 2'b00);
        applyStimulus(1, 1, 0, 0, 1);
        s_dat_i = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rd_gnt", gnt_o, 2'b01);
        checkOutput("rd_s_adr", s_adr_o, 32'h3000_0004);
        checkOutput("rd_s_cyc", s_cyc_o, 1'b1);
        checkOutput("rd_s_stb", s_stb_o, 1'b1);
        checkOutput("rd_s_we", s_we_o, 1'b0);
        checkOutput("rd_s_sel", s_sel_o, 4'hF);
        checkOutput("rd_m0_ack", m0_ack_o, 1'b1);
        checkOutput("rd_m0_dat", m0_dat_o, 32'h1234_5678);
        checkOutput("rd_m1_ack", m1_ack_o, 1'b0);
        checkOutput("rd_m1_dat", m1_dat_o, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd_hold_gnt", gnt_o, 2'b01);
        checkOutput("rd_hold_s_cyc", s_cyc_o, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd_end_gnt", gnt_o, 2'b00);

        // Simultaneous requests: each master does 4 single cycles, grants alternate
        resetDut();
        @(posedge clk);
        #1;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        @(negedge clk);
        checkOutput("alt_first_gnt", gnt_o, 2'b00);
        cnt0 = 0; cnt1 = 0; drop0 = 0; drop1 = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            m0_cyc_i = (cnt0 < 4) && !drop0;
            m0_stb_i = m0_cyc_i;
            m1_cyc_i = (cnt1 < 4) && !drop1;
            m1_stb_i = m1_cyc_i;
            drop0 = 0;
            drop1 = 0;
            #1;
            s_ack_i = s_stb_o;
            s_dat_i = 32'hC0DE_0000 + k;
            @(negedge clk);
            exp_g = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            checkOutput($sformatf("alt_gnt_%0d", k), gnt_o, exp_g);
            checkOutput($sformatf("alt_ack0_%0d", k), m0_ack_o, k % 4 == 1);
            checkOutput($sformatf("alt_ack1_%0d", k), m1_ack_o, k % 4 == 3);
            if (k % 4 == 1) checkOutput($sformatf("alt_dat0_%0d", k), m0_dat_o, 32'hC0DE_0000 + k);
            if (k % 4 == 3) checkOutput($sformatf("alt_dat1_%0d", k), m1_dat_o, 32'hC0DE_0000 + k);
            if (m0_ack_o) begin cnt0++; drop0 = 1; end
            if (m1_ack_o) begin cnt1++; drop1 = 1; end
        end
        checkOutput("alt_total_m0", cnt0, 4);
        checkOutput("alt_total_m1", cnt1, 4);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("alt_end_gnt", gnt_o, 2'b00);

        // Held cycle: m1 keeps cyc over three write beats while m0 waits
        resetDut();
        m1_adr_i = 32'h3000_0010; m1_we_i = 1; m1_sel_i = 4'hF;
        m0_adr_i = 32'h3000_0020; m0_we_i = 0;
        applyStimulus(0, 0, 1, 1, 0);
        m1_dat_i = 32'hA;
        @(negedge clk);
        checkOutput("hold_c0_gnt", gnt_o, 2'b00);
        applyStimulus(1, 1, 1, 1, 1);
        m1_dat_i = 32'hA;
        @(negedge clk);
        checkOutput("hold_c1_gnt", gnt_o, 2'b10);
        checkOutput("hold_c1_adr", s_adr_o, 32'h3000_0010);
        checkOutput("hold_c1_m1_ack", m1_ack_o, 1'b1);
        checkOutput("hold_c1_m0_ack", m0_ack_o, 1'b0);
        if (s_stb_o && s_we_o && s_ack_i) wr_q.push_back(s_dat_o);
        applyStimulus(1, 1, 1, 1, 1);
        m1_dat_i = 32'hB;
        @(negedge clk);
        checkOutput("hold_c2_gnt", gnt_o, 2'b10);
        if (s_stb_o && s_we_o && s_ack_i) wr_q.push_back(s_dat_o);
        applyStimulus(1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("hold_c3_gnt", gnt_o, 2'b10);
        checkOutput("hold_c3_s_cyc", s_cyc_o, 1'b1);
        checkOutput("hold_c3_s_stb", s_stb_o, 1'b0);
        applyStimulus(1, 1, 1, 1, 1);
        m1_dat_i = 32'hC;
        @(negedge clk);
        checkOutput("hold_c4_gnt", gnt_o, 2'b10);
        if (s_stb_o && s_we_o && s_ack_i) wr_q.push_back(s_dat_o);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("hold_c5_gnt", gnt_o, 2'b10);
        checkOutput("hold_c5_m0_ack", m0_ack_o, 1'b0);
        applyStimulus(1, 1, 0, 0, 1);
        s_dat_i = 32'h77;
        @(negedge clk);
        checkOutput("hold_c6_gnt", gnt_o, 2'b01);
        checkOutput("hold_c6_adr", s_adr_o, 32'h3000_0020);
        checkOutput("hold_c6_m0_ack", m0_ack_o, 1'b1);
        checkOutput("hold_c6_m0_dat", m0_dat_o, 32'h77);
        exp_wr[0] = 32'hA; exp_wr[1] = 32'hB; exp_wr[2] = 32'hC;
        checkOutput("hold_wr_count", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++)
            checkOutput($sformatf("hold_wr_%0d", i), wr_q[i], exp_wr[i]);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset mid-transfer: after a GNT0 the live pointer favours m1, reset must restore m0
        resetDut();
        m0_adr_i = 32'h3000_0004; m0_we_i = 0;
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("mrst_pre_gnt", gnt_o, 2'b01);
        #2;
        rst_n_i = 1'b0;
        s_ack_i = 1'b1;
        #1;
        checkOutput("mrst_s_cyc", s_cyc_o, 1'b0);
        checkOutput("mrst_s_stb", s_stb_o, 1'b0);
        checkOutput("mrst_gnt", gnt_o, 2'b00);
        checkOutput("mrst_m0_ack", m0_ack_o, 1'b0);
        m1_cyc_i = 1; m1_stb_i = 1;
        @(posedge clk);
        @(negedge clk);
        s_ack_i = 1'b0;
        #2 rst_n_i = 1'b1;
        @(negedge clk);
        checkOutput("mrst_both_gnt", gnt_o, 2'b01);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        @(negedge clk);
        checkOutput("mrst_m1_gnt", gnt_o, 2'b10);
        applyStimulus(0, 0, 0, 0, 0);

        // Unanswered m0 read: forced error ack with the watchdog, endless wait without it
        resetDut();
        m0_adr_i = 32'h3000_0008; m0_we_i = 0;
        applyStimulus(1, 1, 0, 0, 0);
        nack = 0; nto = 0; ack_k = 0; to_k = 0;
`ifdef MS_WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (nack > 0) m0_stb_i = 0;
            @(negedge clk);
            if (m0_ack_o) begin
                nack++;
                ack_k = k;
                checkOutput("to_dat", m0_dat_o, 32'hDEADBEEF);
                checkOutput("to_s_stb", s_stb_o, 1'b0);
            end
            if (timeout_o) begin
                nto++;
                to_k = k;
            end
        end
        checkOutput("to_ack_count", nack, 1);
        checkOutput("to_pulse_count", nto, 1);
        checkOutput("to_ack_cycle", ack_k, 9);
        checkOutput("to_pulse_cycle", to_k, 9);
        checkOutput("to_gnt_held", gnt_o, 2'b01);
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (m0_ack_o) nack++;
            if (timeout_o) nto++;
        end
        checkOutput("nto_ack_count", nack, 0);
        checkOutput("nto_pulse_count", nto, 0);
        checkOutput("nto_gnt_held", gnt_o, 2'b01);
        checkOutput("nto_s_stb", s_stb_o, 1'b1);
`endif
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("to_end_gnt", gnt_o, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
